// File: rtl/rect_pkg.sv
// Shared types and conduction patterns for the rectifier gate sequencer.
// Pattern layout is {gate_n[2:0], gate_p[2:0]}, leg bit order A=0, B=1, C=2.
package rect_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [5:0] PAT_NONE = 6'b000_000;
    localparam logic [5:0] PAT_S1   = 6'b010_001;  // Ap, Bn
    localparam logic [5:0] PAT_S2   = 6'b100_001;  // Ap, Cn
    localparam logic [5:0] PAT_S3   = 6'b100_010;  // Bp, Cn
    localparam logic [5:0] PAT_S4   = 6'b001_010;  // Bp, An
    localparam logic [5:0] PAT_S5   = 6'b001_100;  // Cp, An
    localparam logic [5:0] PAT_S6   = 6'b010_100;  // Cp, Bn

    // Sector that follows s in rotation; sector 6 wraps back to 1.
    function automatic logic [2:0] next_sector(input logic [2:0] s);
        if (s == 3'd6) begin
            return 3'd1;
        end
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/rect_pattern_lut.sv
// Combinational sector/judge to conduction-pattern decoder.
// Illegal sectors (0 and 7) decode to all-off and raise the illegal flag.
module rect_pattern_lut
    import rect_pkg::*;
(
    input  logic [2:0] grid_sector,
    input  logic       grid_judge,
    output logic [5:0] pattern,
    output logic       illegal
);

    logic [2:0] eff_sector;

    // Pick the effective sector and look up its two-switch pattern.
    always_comb begin
        pattern    = PAT_NONE;
        illegal    = (grid_sector == 3'd0) || (grid_sector == 3'd7);
        eff_sector = grid_judge ? next_sector(grid_sector) : grid_sector;
        if (!illegal) begin
            case (eff_sector)
                3'd1:    pattern = PAT_S1;
                3'd2:    pattern = PAT_S2;
                3'd3:    pattern = PAT_S3;
                3'd4:    pattern = PAT_S4;
                3'd5:    pattern = PAT_S5;
                3'd6:    pattern = PAT_S6;
                default: pattern = PAT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/rectifier_gate_seq.sv
// Registered six-switch gate sequencer for the grid-side active rectifier.
// Turn-offs are applied on the next edge; every turn-on waits DEAD_CYC cycles,
// and the dead-time count restarts whenever the target changes mid-wait.
module rectifier_gate_seq
    import rect_pkg::*;
#(
    parameter int DEAD_CYC = 50,
    parameter int CNT_W    = 8
) (
    input  logic       sysclk,
    input  logic       global_rst,
    input  logic [2:0] grid_sector,
    input  logic       grid_judge,
    input  logic       SD,
    input  logic       DOV,
    input  logic       fault_clr,
    output logic [2:0] gate_p,
    output logic [2:0] gate_n,
    output logic       fault,
    output logic       sector_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       gates_q, gates_d;
    logic [5:0]       tgt_q;
    logic             sector_err_q;

    logic [5:0]       lut_pattern;
    logic             lut_illegal;
    logic [5:0]       tgt;

    rect_pattern_lut u_lut (
        .grid_sector (grid_sector),
        .grid_judge  (grid_judge),
        .pattern     (lut_pattern),
        .illegal     (lut_illegal)
    );

    assign tgt = lut_illegal ? PAT_NONE : lut_pattern;

    // Next state, dead-time counter and gate vector; fault and guard override last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gates_d = gates_q;
        case (state_q)
            OFF: begin
                gates_d = PAT_NONE;
                if (SD && (tgt != PAT_NONE)) begin
                    state_d = DEAD;
                    cnt_d   = RELOAD;
                end
            end
            DEAD: begin
                if (!SD) begin
                    state_d = OFF;
                    gates_d = PAT_NONE;
                end else if (tgt != tgt_q) begin
                    // Target moved while waiting: drop what it no longer wants, restart.
                    gates_d = gates_q & tgt;
                    cnt_d   = RELOAD;
                end else if (cnt_q == '0) begin
                    gates_d = tgt;
                    state_d = RUN;
                end else begin
                    gates_d = gates_q & tgt;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (!SD) begin
                    state_d = OFF;
                    gates_d = PAT_NONE;
                end else if (tgt != gates_q) begin
                    if ((tgt & ~gates_q) == PAT_NONE) begin
                        // Pure turn-off never needs dead time.
                        gates_d = tgt;
                    end else begin
                        state_d = DEAD;
                        gates_d = gates_q & tgt;
                        cnt_d   = RELOAD;
                    end
                end
            end
            FAULT: begin
                gates_d = PAT_NONE;
                if (fault_clr && DOV && SD) begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
                gates_d = PAT_NONE;
            end
        endcase

        // Overvoltage beats everything, including a same-cycle fault_clr or SD=0.
        if (!DOV) begin
            state_d = FAULT;
            gates_d = PAT_NONE;
        end else if ((gates_d[5:3] & gates_d[2:0]) != 3'b000) begin
            // Structural shoot-through guard: never register both switches of a leg.
            state_d = FAULT;
            gates_d = PAT_NONE;
        end
    end

    // State, counter, gate and status registers.
    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            gates_q      <= PAT_NONE;
            tgt_q        <= PAT_NONE;
            sector_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gates_q      <= gates_d;
            tgt_q        <= tgt;
            sector_err_q <= lut_illegal;
        end
    end

    assign gate_p     = gates_q[2:0];
    assign gate_n     = gates_q[5:3];
    assign fault      = (state_q == FAULT);
    assign busy       = (state_q == DEAD);
    assign sector_err = sector_err_q;

endmodule

// File: tb/tb_rectifier_gate_seq.sv
// Directed plus randomised bench for rectifier_gate_seq with a cycle-stamped scoreboard.
module tb_rectifier_gate_seq;

    localparam int DC = 50;

    logic       sysclk = 1'b0;
    logic       global_rst = 1'b0;
    logic [2:0] grid_sector = 3'd1;
    logic       grid_judge = 1'b0;
    logic       SD = 1'b1;
    logic       DOV = 1'b1;
    logic       fault_clr = 1'b0;
    logic [2:0] gate_p, gate_n;
    logic       fault, sector_err, busy;

    always #5 sysclk = ~sysclk;

    rectifier_gate_seq #(.DEAD_CYC(DC), .CNT_W(8)) dut (
        .sysclk      (sysclk),
        .global_rst  (global_rst),
        .grid_sector (grid_sector),
        .grid_judge  (grid_judge),
        .SD          (SD),
        .DOV         (DOV),
        .fault_clr   (fault_clr),
        .gate_p      (gate_p),
        .gate_n      (gate_n),
        .fault       (fault),
        .sector_err  (sector_err),
        .busy        (busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;

    int unsigned exp_cyc_q[$];
    string       exp_tag_q[$];
    logic [8:0]  exp_val_q[$];

    logic [2:0]  prev_p = 3'b000;
    logic [2:0]  prev_n = 3'b000;
    int          off_p[3] = '{0, 0, 0};
    int          off_n[3] = '{0, 0, 0};

    // Observation vector layout: {fault, sector_err, busy, gate_n, gate_p}.
    function automatic logic [8:0] mk(input logic f, input logic e, input logic b,
                                      input logic [2:0] n, input logic [2:0] p);
        return {f, e, b, n, p};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic exp_at(input int unsigned k, input string tag, input logic [8:0] v);
        exp_cyc_q.push_back(cyc + k);
        exp_tag_q.push_back(tag);
        exp_val_q.push_back(v);
    endtask

    // One clock: sample on the falling edge, pop due expectations, run leg monitors.
    task automatic tick();
        logic [8:0] obs;
        @(posedge sysclk);
        cyc++;
        @(negedge sysclk);
        obs = {fault, sector_err, busy, gate_n, gate_p};
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            check(exp_tag_q[0], obs, exp_val_q[0]);
            $display("txn cyc=%0d %s obs=%b exp=%b", cyc, exp_tag_q[0], obs, exp_val_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_tag_q.pop_front());
            void'(exp_val_q.pop_front());
        end
        check("no_shoot_through", {6'b0, gate_p & gate_n}, 9'b0);
        for (int i = 0; i < 3; i++) begin
            if (gate_p[i] && !prev_p[i]) begin
                n_cmp++;
                assert (off_n[i] >= DC)
                else begin
                    n_bad++;
                    $error("FAIL dead_p%0d cyc=%0d observed=%0d required>=%0d", i, cyc, off_n[i], DC);
                end
            end
            if (gate_n[i] && !prev_n[i]) begin
                n_cmp++;
                assert (off_p[i] >= DC)
                else begin
                    n_bad++;
                    $error("FAIL dead_n%0d cyc=%0d observed=%0d required>=%0d", i, cyc, off_p[i], DC);
                end
            end
            off_p[i] = gate_p[i] ? 0 : off_p[i] + 1;
            off_n[i] = gate_n[i] ? 0 : off_n[i] + 1;
        end
        prev_p = gate_p;
        prev_n = gate_n;
    endtask

    // Run until every pending expectation has been compared, within a cycle budget.
    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_cyc_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (exp_cyc_q.size() == 0)
        else begin
            n_bad++;
            $error("FAIL drain_timeout cyc=%0d observed=%0d pending required=0", cyc, exp_cyc_q.size());
        end
        exp_cyc_q.delete();
        exp_tag_q.delete();
        exp_val_q.delete();
    endtask

    initial begin
        logic sd_lo, dov_lo;

        // Held in reset: everything low.
        exp_at(1, "rst_a", 9'b0);
        exp_at(3, "rst_b", 9'b0);
        drain(10);

        // Power-up into sector 1.
        global_rst = 1'b1;
        exp_at(1,  "pu_dead_first", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC, "pu_dead_last",  mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 1, "pu_run_s1", mk(0, 0, 0, 3'b010, 3'b001));
        drain(DC + 10);

        // Sector 1 -> 2: Bn drops next cycle, Cn after dead time, Ap held.
        grid_sector = 3'd2;
        exp_at(1,  "s12_bn_off",  mk(0, 0, 1, 3'b000, 3'b001));
        exp_at(DC, "s12_dead",    mk(0, 0, 1, 3'b000, 3'b001));
        exp_at(DC + 1, "s12_cn_on", mk(0, 0, 0, 3'b100, 3'b001));
        drain(DC + 10);

        // fault_clr in RUN is ignored.
        fault_clr = 1'b1;
        exp_at(1, "clr_in_run", mk(0, 0, 0, 3'b100, 3'b001));
        tick();
        fault_clr = 1'b0;

        // DOV pulse latches fault; clear ignored while DOV low.
        DOV = 1'b0;
        exp_at(1, "dov_fault", mk(1, 0, 0, 3'b000, 3'b000));
        tick();
        DOV = 1'b1;
        tick();
        DOV = 1'b0;
        fault_clr = 1'b1;
        exp_at(1, "clr_vs_dov", mk(1, 0, 0, 3'b000, 3'b000));
        tick();
        DOV = 1'b1;
        fault_clr = 1'b0;
        exp_at(1, "fault_held", mk(1, 0, 0, 3'b000, 3'b000));
        tick();
        fault_clr = 1'b1;
        exp_at(1, "clr_off",  mk(0, 0, 0, 3'b000, 3'b000));
        exp_at(2, "clr_dead", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 1, "clr_dead_last", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 2, "clr_restore",   mk(0, 0, 0, 3'b100, 3'b001));
        tick();
        fault_clr = 1'b0;
        drain(DC + 10);

        // judge=1 with sector 6 selects the sector-1 pattern.
        grid_judge  = 1'b1;
        grid_sector = 3'd6;
        exp_at(1, "j6_cn_off", mk(0, 0, 1, 3'b000, 3'b001));
        exp_at(DC + 1, "j6_s1", mk(0, 0, 0, 3'b010, 3'b001));
        drain(DC + 10);

        // Illegal sector: all off, error flag one cycle later.
        grid_sector = 3'd7;
        exp_at(1, "sec7_off", mk(0, 1, 0, 3'b000, 3'b000));
        drain(5);
        grid_judge  = 1'b0;
        grid_sector = 3'd3;
        exp_at(1, "s3_dead", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 1, "s3_on", mk(0, 0, 0, 3'b100, 3'b010));
        drain(DC + 10);

        // Toggle 1 -> 2 -> 3 inside dead time: no turn-on until after the last change.
        grid_sector = 3'd1;
        exp_at(1,  "tog1_dead", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(10, "tog1_hold", mk(0, 0, 1, 3'b000, 3'b000));
        repeat (10) tick();
        grid_sector = 3'd2;
        exp_at(5,  "tog2_hold", mk(0, 0, 1, 3'b000, 3'b000));
        repeat (10) tick();
        grid_sector = 3'd3;
        exp_at(DC, "tog3_hold", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 1, "tog3_on", mk(0, 0, 0, 3'b100, 3'b010));
        drain(DC + 10);

        // SD low in RUN: immediate off, then full dead time on release.
        SD = 1'b0;
        exp_at(1, "sd_off", mk(0, 0, 0, 3'b000, 3'b000));
        tick();
        SD = 1'b1;
        exp_at(1, "sd_rel_dead", mk(0, 0, 1, 3'b000, 3'b000));
        exp_at(DC + 1, "sd_rel_on", mk(0, 0, 0, 3'b100, 3'b010));
        drain(DC + 10);

        // SD and DOV low together: FAULT wins.
        SD  = 1'b0;
        DOV = 1'b0;
        exp_at(1, "sd_dov_fault", mk(1, 0, 0, 3'b000, 3'b000));
        tick();
        SD = 1'b1;
        DOV = 1'b1;
        fault_clr = 1'b1;
        exp_at(1, "sd_dov_clr", mk(0, 0, 0, 3'b000, 3'b000));
        tick();
        fault_clr = 1'b0;
        exp_at(DC + 1, "sd_dov_restore", mk(0, 0, 0, 3'b100, 3'b010));
        drain(DC + 10);

        // Randomised sector/SD/DOV traffic with leg monitors running every cycle.
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                grid_sector = 3'($urandom_range(0, 7));
                grid_judge  = 1'($urandom_range(0, 1));
            end
            SD        = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            DOV       = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            fault_clr = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
            sd_lo  = !SD;
            dov_lo = !DOV;
            tick();
            if (dov_lo) begin
                check("rnd_dov_fault", {2'b00, fault, gate_n, gate_p}, 9'b001_000_000);
            end else if (sd_lo) begin
                check("rnd_sd_off", {3'b000, gate_n, gate_p}, 9'b0);
            end
        end
        SD = 1'b1;
        DOV = 1'b1;
        fault_clr = 1'b0;
        drain(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
